fetch_stage: RTL and testbench

//   IF stage of the 5-stage pipeline: owns the program counter, drives the

---
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads the combinational instruction memory and fills IF/ID.
// Optional FETCH_PERF_CNT_EN adds fetched-instruction and stall-cycle counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic        if_id_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`else
  output logic        if_id_valid
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  // Redirect outranks stall; a bubble keeps the old IF/ID pc so pc4 stays coherent.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (redirect_valid) begin
      pc_d       = {redirect_target[31:2], 2'b00};
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d       = pc_q + 32'd4;
      id_pc_d    = pc_q;
      id_instr_d = imem_instr;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0000_0000;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_pc4   = id_pc_q + 32'd4;
  assign if_id_instr = id_instr_q;
  assign if_id_valid = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else if (!redirect_valid) begin
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free fetch, stall, redirect, PC wrap, async reset.
// Memory word at byte address A is 0x1000_0000 | A[31:2], except word 3 holds lw 0x8C01_0000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_instr    (if_id_instr),
`ifdef FETCH_PERF_CNT_EN
    .if_id_valid    (if_id_valid),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`else
    .if_id_valid    (if_id_valid)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr == 32'h0000_000C) imem_instr = 32'h8C01_0000;
    else imem_instr = 32'h1000_0000 | {2'b00, imem_addr[31:2]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                             input logic [31:0] instr, input logic valid);
    check({tag, ".imem_addr"}, imem_addr, addr);
    check({tag, ".if_id_pc"}, if_id_pc, pc);
    check({tag, ".if_id_pc4"}, if_id_pc4, pc + 32'd4);
    check({tag, ".if_id_instr"}, if_id_instr, instr);
    check({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0000_0000;
    #12;
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    #2;
    check_state("released", 32'h0, 32'h0, 32'h0, 1'b0);

    // Free fetch from RESET_PC
    edge_step(); check_state("edge1", 32'h4, 32'h0, 32'h1000_0000, 1'b1);
    edge_step(); check_state("edge2", 32'h8, 32'h4, 32'h1000_0001, 1'b1);
    edge_step(); check_state("edge3", 32'hC, 32'h8, 32'h1000_0002, 1'b1);
    edge_step(); check_state("lw", 32'h10, 32'hC, 32'h8C01_0000, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd4);
    check("perf_stall0", perf_stall_cnt, 32'd0);
`endif

    // Two stall cycles hold everything
    stall = 1'b1;
    edge_step(); check_state("stall1", 32'h10, 32'hC, 32'h8C01_0000, 1'b1);
    edge_step(); check_state("stall2", 32'h10, 32'hC, 32'h8C01_0000, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall2", perf_stall_cnt, 32'd2);
`endif

    // Redirect overrides stall, low bits of target dropped
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0027;
    edge_step(); check_state("redir", 32'h24, 32'hC, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall_redir", perf_stall_cnt, 32'd2);
    check("perf_fetch_redir", perf_fetch_cnt, 32'd4);
`endif
    redirect_valid = 1'b0;
    stall          = 1'b0;
    edge_step(); check_state("after_redir", 32'h28, 32'h24, 32'h1000_0009, 1'b1);

    // Back-to-back redirects, the last one to the top word
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    edge_step(); check_state("b2b1", 32'h100, 32'h24, 32'h0, 1'b0);
    redirect_target = 32'h0000_0200;
    edge_step(); check_state("b2b2", 32'h200, 32'h24, 32'h0, 1'b0);
    redirect_target = 32'hFFFF_FFFF;
    edge_step(); check_state("to_top", 32'hFFFF_FFFC, 32'h24, 32'h0, 1'b0);
    redirect_valid = 1'b0;
    edge_step(); check_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 1'b1);
    check("wrap.pc4_zero", if_id_pc4, 32'h0000_0000);

    // Redirect to the current pc still squashes one slot
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0000;
    edge_step(); check_state("self_redir", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    redirect_valid = 1'b0;
    edge_step(); check_state("self_after", 32'h4, 32'h0, 32'h1000_0000, 1'b1);

    // Async reset in the middle of a stall, between edges
    stall = 1'b1;
    edge_step(); check_state("pre_rst", 32'h4, 32'h0, 32'h1000_0000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    check("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
